i2c_clk_gen: RTL and testbench

- Parametrised successor to the fixed half-period clock divider.
- Generates the I2C bus clock from the 50 MHz system clock with a runtime-programmable half-period, start/stop control and an idle level.
- Produces single-cycle phase strobes (fall, data-change, rise, sample) so the I2C master FSM can step on ticks rather than on a derived clock.
- Sits between the system clock and the I2C master/EEPROM controller.

---
 rtl/i2c_pkg.sv | 36 +++
 rtl/i2c_clk_gen.sv | 199 +++++++++++++++++++
 tb/tb_i2c_clk_gen.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C bus clock generator:
//   - state_e     : generator states (IDLE / LOW / HIGH)
//   - SYS_CLK_HZ  : system clock frequency the divider values assume
//   - HALF_100K / HALF_400K : half-period counts for standard / fast mode
//   - eff_half()  : maps a raw div_half request onto the half-period in use
// -----------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_e;

  localparam int unsigned SYS_CLK_HZ = 50_000_000;
  localparam int unsigned HALF_100K  = 250;
  localparam int unsigned HALF_400K  = 63;

  // 0 selects the default half-period; 1 is clamped to 2 so the
  // mid-phase strobe never collides with the phase-end strobe.
  function automatic logic [31:0] eff_half(input logic [31:0] div_half,
                                           input logic [31:0] default_half);
    logic [31:0] h;
    if (div_half == 32'd0) begin
      h = default_half;
    end else if (div_half == 32'd1) begin
      h = 32'd2;
    end else begin
      h = div_half;
    end
    return h;
  endfunction

endpackage

// File: rtl/i2c_clk_gen.sv
// -----------------------------------------------------------------------------
// i2c_clk_gen
// Generates the I2C bus clock from the system clock with a runtime
// programmable half-period, plus single-cycle phase strobes that let the I2C
// master step on ticks instead of on a derived clock.
//
// Optional feature macro: I2C_CLK_STRETCH_EN (slave clock stretching in HIGH).
//
// Ports:
//   clk_in      in   system clock
//   reset       in   asynchronous active-high reset
//   en          in   run request (sampled in IDLE and at the end of HIGH)
//   div_half    in   clk_in cycles per half-period (0 -> DEFAULT_HALF, 1 -> 2)
//   clk_out     out  generated bus clock (registered, 50% duty)
//   fall_tick   out  first cycle of the low phase
//   data_tick   out  middle of the low phase (SDA may change)
//   rise_tick   out  first cycle of the high phase
//   sample_tick out  middle of the high phase (SDA valid)
//   busy        out  high in LOW and HIGH
//   scl_sense   in   sensed SCL level          (I2C_CLK_STRETCH_EN only)
//   stretched   out  high phase is being held  (I2C_CLK_STRETCH_EN only)
// -----------------------------------------------------------------------------
module i2c_clk_gen
  import i2c_pkg::*;
#(
  parameter int unsigned DIV_W        = 16,
  parameter int unsigned DEFAULT_HALF = 250,
  parameter logic        IDLE_LEVEL   = 1'b1
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] div_half,
`ifdef I2C_CLK_STRETCH_EN
  input  logic             scl_sense,
  output logic             stretched,
`endif
  output logic             clk_out,
  output logic             fall_tick,
  output logic             data_tick,
  output logic             rise_tick,
  output logic             sample_tick,
  output logic             busy
);

  localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] CNT_ZERO = DIV_W'(0);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] half_q, half_d;
  logic             clk_out_q, clk_out_d;
  logic             fall_q, fall_d;
  logic             data_q, data_d;
  logic             rise_q, rise_d;
  logic             sample_q, sample_d;
  logic             busy_q, busy_d;
  logic [DIV_W-1:0] h_s;
  logic [DIV_W-1:0] half_mid_s;
  logic [DIV_W-1:0] half_last_s;
  logic             hold_s;
`ifdef I2C_CLK_STRETCH_EN
  logic             stretched_q, stretched_d;
`endif

  // Effective half-period and the two compare points inside a phase
  assign h_s         = DIV_W'(eff_half(32'(div_half), 32'(DEFAULT_HALF)));
  assign half_mid_s  = (half_q >> 1) - CNT_ONE;
  assign half_last_s = half_q - CNT_ONE;

  // High-phase hold request from a slave pulling SCL low
`ifdef I2C_CLK_STRETCH_EN
  assign hold_s = ~scl_sense;
`else
  assign hold_s = 1'b0;
`endif

  // State register and registered outputs
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= CNT_ZERO;
      half_q      <= DIV_W'(DEFAULT_HALF);
      clk_out_q   <= IDLE_LEVEL;
      fall_q      <= 1'b0;
      data_q      <= 1'b0;
      rise_q      <= 1'b0;
      sample_q    <= 1'b0;
      busy_q      <= 1'b0;
`ifdef I2C_CLK_STRETCH_EN
      stretched_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      half_q      <= half_d;
      clk_out_q   <= clk_out_d;
      fall_q      <= fall_d;
      data_q      <= data_d;
      rise_q      <= rise_d;
      sample_q    <= sample_d;
      busy_q      <= busy_d;
`ifdef I2C_CLK_STRETCH_EN
      stretched_q <= stretched_d;
`endif
    end
  end

  // Next-state, counter and strobe generation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    half_d      = half_q;
    clk_out_d   = clk_out_q;
    fall_d      = 1'b0;
    data_d      = 1'b0;
    rise_d      = 1'b0;
    sample_d    = 1'b0;
`ifdef I2C_CLK_STRETCH_EN
    stretched_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d   = ST_LOW;
          cnt_d     = CNT_ZERO;
          clk_out_d = 1'b0;
          fall_d    = 1'b1;
          half_d    = h_s;
        end else begin
          clk_out_d = IDLE_LEVEL;
        end
      end
      ST_LOW: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == half_mid_s) begin
          data_d = 1'b1;
        end else begin
          data_d = 1'b0;
        end
        if (cnt_q == half_last_s) begin
          state_d   = ST_HIGH;
          cnt_d     = CNT_ZERO;
          clk_out_d = 1'b1;
          rise_d    = 1'b1;
        end else begin
          state_d   = ST_LOW;
        end
      end
      ST_HIGH: begin
        if (hold_s) begin
          // Counter frozen; strobes suppressed so they are not repeated
          cnt_d       = cnt_q;
`ifdef I2C_CLK_STRETCH_EN
          stretched_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == half_mid_s) begin
            sample_d = 1'b1;
          end else begin
            sample_d = 1'b0;
          end
          if (cnt_q == half_last_s) begin
            cnt_d = CNT_ZERO;
            if (en) begin
              state_d   = ST_LOW;
              clk_out_d = 1'b0;
              fall_d    = 1'b1;
              half_d    = h_s;
            end else begin
              state_d   = ST_IDLE;
              clk_out_d = IDLE_LEVEL;
            end
          end else begin
            state_d = ST_HIGH;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        cnt_d     = CNT_ZERO;
        clk_out_d = IDLE_LEVEL;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign clk_out     = clk_out_q;
  assign fall_tick   = fall_q;
  assign data_tick   = data_q;
  assign rise_tick   = rise_q;
  assign sample_tick = sample_q;
  assign busy        = busy_q;
`ifdef I2C_CLK_STRETCH_EN
  assign stretched   = stretched_q;
`endif

endmodule

// File: tb/tb_i2c_clk_gen.sv
// -----------------------------------------------------------------------------
// tb_i2c_clk_gen
// Directed bench for i2c_clk_gen: expected strobe events (kind + cycle) are
// queued when stimulus is applied and popped as the DUT raises each strobe.
// -----------------------------------------------------------------------------
module tb_i2c_clk_gen;

  localparam int DIV_W = 16;

  typedef struct {
    string tag;
    int    kind;   // 0 fall, 1 data, 2 rise, 3 sample
    int    cyc;
  } ev_t;

  logic             clk_in = 1'b0;
  logic             reset;
  logic             en;
  logic [DIV_W-1:0] div_half;
  logic             scl_sense;
  logic             clk_out, fall_tick, data_tick, rise_tick, sample_tick, busy;
`ifdef I2C_CLK_STRETCH_EN
  logic             stretched;
`endif

  int  checks = 0;
  int  errors = 0;
  int  cyc    = 0;
  int  nf;
  ev_t q[$];

  i2c_clk_gen #(.DIV_W(DIV_W), .DEFAULT_HALF(250), .IDLE_LEVEL(1'b1)) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .en          (en),
    .div_half    (div_half),
`ifdef I2C_CLK_STRETCH_EN
    .scl_sense   (scl_sense),
    .stretched   (stretched),
`endif
    .clk_out     (clk_out),
    .fall_tick   (fall_tick),
    .data_tick   (data_tick),
    .rise_tick   (rise_tick),
    .sample_tick (sample_tick),
    .busy        (busy)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_ev(input string tag, input int kind, input int c);
    q.push_back('{tag: tag, kind: kind, cyc: c});
  endtask

  // One full period starting with a fall at cycle f, half-period h
  task automatic push_period(input int f, input int h);
    push_ev("fall",   0, f);
    push_ev("data",   1, f + h / 2);
    push_ev("rise",   2, f + h);
    push_ev("sample", 3, f + h + h / 2);
  endtask

  // Advance to the next falling edge and match any strobe against the queue
  task automatic step();
    ev_t e;
    int  n;
    int  kind;
    @(negedge clk_in);
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      chk({"missed_", e.tag}, cyc, e.cyc);
    end
    n = int'(fall_tick) + int'(data_tick) + int'(rise_tick) + int'(sample_tick);
    if (n != 0) begin
      chk("tick_onehot", n, 1);
      kind = fall_tick ? 0 : (data_tick ? 1 : (rise_tick ? 2 : 3));
      if (q.size() == 0) begin
        chk("unexpected_tick", kind, 99);
      end else begin
        e = q.pop_front();
        chk({e.tag, "_kind"}, kind, e.kind);
        chk({e.tag, "_cycle"}, cyc, e.cyc);
        if (kind == 0) begin
          chk("fall_clk_level", clk_out, 0);
          chk("fall_busy", busy, 1);
        end else if (kind == 2) begin
          chk("rise_clk_level", clk_out, 1);
        end
      end
    end
  endtask

  task automatic run_until(input int t);
    while (cyc < t) step();
  endtask

  initial begin
    reset     = 1'b1;
    en        = 1'b1;
    div_half  = 16'd4;
    scl_sense = 1'b1;

    // Reset state with en already high
    repeat (3) step();
    chk("rst_clk_out", clk_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ticks", {fall_tick, data_tick, rise_tick, sample_tick}, 0);

    // div_half=4: fall +1, data +2, rise +4, sample +6, next fall +8
    reset = 1'b0;
    nf = cyc + 1;
    push_period(nf, 4); nf += 8;
    push_period(nf, 4); nf += 8;
    run_until(nf - 1);

    // div_half=0 -> 250 half, 500-cycle period
    div_half = 16'd0;
    push_period(nf, 250); nf += 500;
    run_until(nf - 1);

    // div_half=1 -> clamped to 2, 4-cycle period
    div_half = 16'd1;
    push_period(nf, 2); nf += 4;
    push_period(nf, 2); nf += 4;
    run_until(nf - 1);

    // Change 4 -> 10 mid-LOW: current period 8, next period 20
    div_half = 16'd4;
    push_period(nf, 4);
    run_until(nf + 1);
    div_half = 16'd10;
    nf += 8;
    push_period(nf, 10); nf += 20;
    run_until(nf - 1);

    // Drop en in cycle 2 of LOW: period completes, then IDLE without a fall
    div_half = 16'd4;
    push_period(nf, 4);
    run_until(nf + 2);
    en = 1'b0;
    run_until(nf + 7);
    chk("stop_last_high_busy", busy, 1);
    chk("stop_last_high_clk", clk_out, 1);
    step();
    chk("stop_idle_clk", clk_out, 1);
    chk("stop_idle_busy", busy, 0);
    repeat (6) step();
    chk("stop_idle_busy_later", busy, 0);

    // Reset mid-HIGH, while sample_tick is active
    en = 1'b1;
    nf = cyc + 1;
    push_period(nf, 4);
    run_until(nf + 6);
    reset = 1'b1;
    #1;
    chk("rst_high_clk", clk_out, 1);
    chk("rst_high_busy", busy, 0);
    chk("rst_high_ticks", {fall_tick, data_tick, rise_tick, sample_tick}, 0);
    step();

    // Reset mid-LOW, while data_tick is active and clk_out is low
    reset = 1'b0;
    nf = cyc + 1;
    push_ev("fall", 0, nf);
    push_ev("data", 1, nf + 2);
    run_until(nf + 2);
    reset = 1'b1;
    #1;
    chk("rst_low_clk", clk_out, 1);
    chk("rst_low_busy", busy, 0);
    chk("rst_low_ticks", {fall_tick, data_tick, rise_tick, sample_tick}, 0);
    step();

`ifdef I2C_CLK_STRETCH_EN
    // Hold SCL low for 5 cycles after rise: sample and next fall slip by 5
    reset = 1'b0;
    nf = cyc + 1;
    push_ev("fall",   0, nf);
    push_ev("data",   1, nf + 2);
    push_ev("rise",   2, nf + 4);
    push_ev("sample", 3, nf + 11);
    push_ev("fall",   0, nf + 13);
    run_until(nf + 4);
    chk("stretch_before", stretched, 0);
    scl_sense = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stretch_active", stretched, 1);
    end
    scl_sense = 1'b1;
    step();
    chk("stretch_released", stretched, 0);
    run_until(nf + 13);
    reset = 1'b1;
    #1;
    chk("rst_stretched", stretched, 0);
`endif

    reset = 1'b1;
    en    = 1'b0;
    repeat (2) step();
    chk("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
